// File: rtl/bus_pkg.sv
// Shared types for the bus arbiter: FSM states, slave ids and the default master id type.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    typedef enum logic [1:0] {
        no_slave,
        slave_1,
        slave_2,
        slave_3
    } slave_t;

    localparam int unsigned MASTER_ID_WIDTH_DEF = 1;

    typedef logic [MASTER_ID_WIDTH_DEF-1:0] master_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational masked round-robin select: first valid requester at or above ptr, else the
// lowest valid requester overall.
module rr_priority_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] winner
);

    logic [N-1:0] masked;
    logic         found_masked;
    logic         found_any;
    logic [W-1:0] win_masked;
    logic [W-1:0] win_any;

    always_comb begin
        masked       = '0;
        found_masked = 1'b0;
        found_any    = 1'b0;
        win_masked   = '0;
        win_any      = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = valid[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < N; i++) begin
            if (!found_masked && masked[i]) begin
                win_masked   = W'(i);
                found_masked = 1'b1;
            end
            if (!found_any && valid[i]) begin
                win_any   = W'(i);
                found_any = 1'b1;
            end
        end
        any    = found_any;
        winner = found_masked ? win_masked : win_any;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter driving the interconnect master/slave selects.
// Define ARB_TIMEOUT_EN to bound each tenure to MAX_HOLD cycles.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MASTER_COUNT    = 2,
    parameter int SLAVE_COUNT     = 3,
    parameter int SLAVE_ID_WIDTH  = $clog2(SLAVE_COUNT + 1),
    parameter int MASTER_ID_WIDTH = (MASTER_COUNT > 1 ? $clog2(MASTER_COUNT) : 1),
    parameter int FIRST_PRIORITY  = 0,
    parameter int MAX_HOLD        = 1000
) (
    input  logic                                       clk,
    input  logic                                       rstN,
    input  logic [MASTER_COUNT-1:0]                    req,
    input  logic [MASTER_COUNT-1:0][SLAVE_ID_WIDTH-1:0] req_slave,
    input  logic [MASTER_COUNT-1:0]                    done,
    output logic [MASTER_COUNT-1:0]                    grant,
    output logic [MASTER_ID_WIDTH-1:0]                 sel_master,
    output logic [SLAVE_ID_WIDTH-1:0]                  sel_slave,
    output logic                                       bus_busy,
    output logic [MASTER_COUNT-1:0]                    req_err,
    output logic                                       timeout
);

    arb_state_t                 state;
    logic [MASTER_ID_WIDTH-1:0] rr_ptr;
    logic [MASTER_ID_WIDTH-1:0] winner;
    logic [MASTER_ID_WIDTH-1:0] rr_next;
    logic [MASTER_COUNT-1:0]    slave_ok;
    logic [MASTER_COUNT-1:0]    valid;
    logic [MASTER_COUNT-1:0]    bad_req;
    logic [MASTER_COUNT-1:0]    err_seen;
    logic                       any_valid;
    logic                       owner_done;
    logic                       owner_abort;
    logic                       expire;
    logic                       timeout_q;

    always_comb begin
        slave_ok = '0;
        for (int m = 0; m < MASTER_COUNT; m++) begin
            slave_ok[m] = (req_slave[m] != '0) &&
                          (req_slave[m] <= SLAVE_ID_WIDTH'(SLAVE_COUNT));
        end
    end

    assign valid   = req & slave_ok;
    assign bad_req = req & ~slave_ok;

    rr_priority_picker #(
        .N (MASTER_COUNT),
        .W (MASTER_ID_WIDTH)
    ) u_picker (
        .valid  (valid),
        .ptr    (rr_ptr),
        .any    (any_valid),
        .winner (winner)
    );

    assign rr_next     = (winner == MASTER_ID_WIDTH'(MASTER_COUNT - 1)) ? '0 : winner + 1'b1;
    assign owner_done  = done[sel_master];
    assign owner_abort = !req[sel_master];

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;

    assign expire = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    logic unused_max_hold;

    assign unused_max_hold = ^MAX_HOLD;
    assign expire          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            grant      <= '0;
            sel_master <= '0;
            sel_slave  <= '0;
            bus_busy   <= 1'b0;
            timeout_q  <= 1'b0;
            rr_ptr     <= MASTER_ID_WIDTH'(FIRST_PRIORITY);
`ifdef ARB_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            unique case (state)
                IDLE, RELEASE: begin
                    if (any_valid) begin
                        state      <= BUSY;
                        grant      <= MASTER_COUNT'(1) << winner;
                        sel_master <= winner;
                        sel_slave  <= req_slave[winner];
                        bus_busy   <= 1'b1;
                        rr_ptr     <= rr_next;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt <= hold_cnt + 1'b1;
`endif
                    if (owner_done || owner_abort || expire) begin
                        state     <= RELEASE;
                        grant     <= '0;
                        sel_slave <= '0;
                        bus_busy  <= 1'b0;
                        // A clean done in the expiry cycle is not a forced end.
                        timeout_q <= expire && !owner_done;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Error pulses once per request assertion; err_seen re-arms when req drops.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            req_err  <= '0;
            err_seen <= '0;
        end else begin
            req_err  <= bad_req & ~err_seen;
            err_seen <= (err_seen | bad_req) & req;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; timeout checks follow ARB_TIMEOUT_EN.
module tb_bus_arbiter;

    logic            clk;
    logic            rstN;
    logic [1:0]      req;
    logic [1:0][1:0] req_slave;
    logic [1:0]      done;
    logic [1:0]      grant;
    logic [0:0]      sel_master;
    logic [1:0]      sel_slave;
    logic            bus_busy;
    logic [1:0]      req_err;
    logic            timeout;

    int vectors = 0;
    int errors  = 0;

    bus_arbiter #(
        .MASTER_COUNT   (2),
        .SLAVE_COUNT    (3),
        .FIRST_PRIORITY (0),
        .MAX_HOLD       (8)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .req        (req),
        .req_slave  (req_slave),
        .done       (done),
        .grant      (grant),
        .sel_master (sel_master),
        .sel_slave  (sel_slave),
        .bus_busy   (bus_busy),
        .req_err    (req_err),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        req  = '0;
        done = '0;
        req_slave = '0;
        tick();
        tick();
        rstN = 1'b1;
        tick();
    endtask

    initial begin
        rstN = 1'b0;
        req  = '0;
        done = '0;
        req_slave = '0;
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sel_master", 32'(sel_master), 32'h0);
        check("rst_sel_slave", 32'(sel_slave), 32'h0);
        check("rst_busy", 32'(bus_busy), 32'h0);
        check("rst_req_err", 32'(req_err), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rstN = 1'b1;
        tick();

        // Single request, with non-owner done and req_slave change ignored
        req = 2'b01;
        req_slave[0] = 2'd1;
        tick();
        check("single_grant", 32'(grant), 32'h1);
        check("single_sel_slave", 32'(sel_slave), 32'h1);
        check("single_busy", 32'(bus_busy), 32'h1);
        check("single_sel_master", 32'(sel_master), 32'h0);
        done = 2'b10;
        req_slave[0] = 2'd3;
        tick();
        done = 2'b00;
        check("nonowner_done_grant", 32'(grant), 32'h1);
        check("captured_sel_slave", 32'(sel_slave), 32'h1);
        done = 2'b01;
        tick();
        done = 2'b00;
        req  = 2'b00;
        check("single_release_grant", 32'(grant), 32'h0);
        check("single_release_busy", 32'(bus_busy), 32'h0);
        check("single_release_slave", 32'(sel_slave), 32'h0);
        tick();
        check("single_idle_grant", 32'(grant), 32'h0);

        // Contention after reset: master 0 first, one idle cycle, then master 1
        do_reset();
        req = 2'b11;
        req_slave[0] = 2'd2;
        req_slave[1] = 2'd3;
        tick();
        check("cont_grant0", 32'(grant), 32'h1);
        check("cont_slave0", 32'(sel_slave), 32'h2);
        done = 2'b01;
        tick();
        done = 2'b00;
        req  = 2'b10;
        check("cont_release_grant", 32'(grant), 32'h0);
        check("cont_release_master", 32'(sel_master), 32'h0);
        tick();
        check("cont_grant1", 32'(grant), 32'h2);
        check("cont_slave1", 32'(sel_slave), 32'h3);
        check("cont_master1", 32'(sel_master), 32'h1);
        done = 2'b10;
        req  = 2'b00;
        tick();
        done = 2'b00;
        tick();

        // Fairness: both requesting continuously, rr_ptr back at 0
        req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check($sformatf("fair_grant%0d", k), 32'(grant), 32'(exp_g));
            done = exp_g;
            tick();
            done = 2'b00;
            check($sformatf("fair_release%0d", k), 32'(grant), 32'h0);
        end
        req = 2'b00;
        tick();

        // Abort: owner drops req
        req = 2'b01;
        req_slave[0] = 2'd1;
        tick();
        check("abort_grant", 32'(grant), 32'h1);
        req = 2'b00;
        tick();
        check("abort_release", 32'(grant), 32'h0);
        tick();

        // Invalid target: single req_err pulse, no grant
        req = 2'b10;
        req_slave[1] = 2'd0;
        tick();
        check("inv_req_err", 32'(req_err), 32'h2);
        check("inv_grant", 32'(grant), 32'h0);
        check("inv_busy", 32'(bus_busy), 32'h0);
        tick();
        check("inv_req_err_once", 32'(req_err), 32'h0);
        check("inv_grant_still", 32'(grant), 32'h0);
        req = 2'b00;
        tick();
        req = 2'b10;
        tick();
        check("inv_req_err_rearm", 32'(req_err), 32'h2);
        req = 2'b00;
        tick();

        // Hold without done: forced end after 8 cycles only with ARB_TIMEOUT_EN
        do_reset();
        req = 2'b11;
        req_slave[0] = 2'd1;
        req_slave[1] = 2'd2;
        tick();
        check("hold_grant_first", 32'(grant), 32'h1);
        for (int k = 0; k < 7; k++) tick();
        check("hold_grant_last", 32'(grant), 32'h1);
        check("hold_no_timeout", 32'(timeout), 32'h0);
        tick();
`ifdef ARB_TIMEOUT_EN
        check("to_release_grant", 32'(grant), 32'h0);
        check("to_pulse", 32'(timeout), 32'h1);
        tick();
        check("to_next_grant", 32'(grant), 32'h2);
        check("to_pulse_end", 32'(timeout), 32'h0);
`else
        check("unlimited_grant", 32'(grant), 32'h1);
        check("unlimited_timeout", 32'(timeout), 32'h0);
        tick();
        check("unlimited_grant2", 32'(grant), 32'h1);
`endif

        // Async reset mid-tenure, then arbitration restarts at master 0
        do_reset();
        req = 2'b01;
        req_slave[0] = 2'd3;
        tick();
        check("ar_grant_before", 32'(grant), 32'h1);
        #2;
        rstN = 1'b0;
        #1;
        check("ar_grant", 32'(grant), 32'h0);
        check("ar_busy", 32'(bus_busy), 32'h0);
        check("ar_slave", 32'(sel_slave), 32'h0);
        req = 2'b11;
        req_slave[1] = 2'd2;
        tick();
        rstN = 1'b1;
        tick();
        check("ar_first_grant", 32'(grant), 32'h1);
        check("ar_first_slave", 32'(sel_slave), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
